// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: shifts a - b out LSB first, one bit per cycle,
// then presents the parallel difference and the final borrow with a done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             d_bit,
    output logic             d_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a, r_b, r_dsh;
    logic [WIDTH-1:0]  w_a_nxt, w_b_nxt, w_dsh_nxt;
    logic              r_bi, w_bi_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_busy, r_d_bit, r_d_valid, r_borrow, r_done;
    logic              w_busy_nxt, w_d_bit_nxt, w_d_valid_nxt, w_borrow_nxt, w_done_nxt;
    logic [WIDTH-1:0]  r_diff, w_diff_nxt;

    // One subtract step; the first step is taken on the accept edge straight
    // from the inputs (borrow-in cleared) so d_bit is valid the next cycle.
    logic w_x, w_y, w_bi, w_d, w_bo;
    always_comb begin
        w_x  = (r_state == IDLE) ? a[0] : r_a[0];
        w_y  = (r_state == IDLE) ? b[0] : r_b[0];
        w_bi = (r_state == IDLE) ? 1'b0 : r_bi;
        w_d  = w_x ^ w_y ^ w_bi;
        w_bo = (~w_x & w_y) | (~(w_x ^ w_y) & w_bi);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_dsh_nxt     = r_dsh;
        w_bi_nxt      = r_bi;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = 1'b0;
        w_d_bit_nxt   = 1'b0;
        w_d_valid_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_diff_nxt    = r_diff;
        w_borrow_nxt  = r_borrow;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = RUN;
                    w_a_nxt       = a >> 1;
                    w_b_nxt       = b >> 1;
                    w_bi_nxt      = w_bo;
                    w_cnt_nxt     = '0;
                    w_dsh_nxt     = {w_d, r_dsh[WIDTH-1:1]};
                    w_busy_nxt    = 1'b1;
                    w_d_valid_nxt = 1'b1;
                    w_d_bit_nxt   = w_d;
                end
            end
            RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt  = DONE;
                    w_done_nxt   = 1'b1;
                    w_diff_nxt   = r_dsh;
                    w_borrow_nxt = r_bi;
                end else begin
                    w_a_nxt       = r_a >> 1;
                    w_b_nxt       = r_b >> 1;
                    w_bi_nxt      = w_bo;
                    w_cnt_nxt     = r_cnt + CW'(1);
                    w_dsh_nxt     = {w_d, r_dsh[WIDTH-1:1]};
                    w_busy_nxt    = 1'b1;
                    w_d_valid_nxt = 1'b1;
                    w_d_bit_nxt   = w_d;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_dsh     <= '0;
            r_bi      <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_d_bit   <= 1'b0;
            r_d_valid <= 1'b0;
            r_done    <= 1'b0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
        end else begin
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_dsh     <= w_dsh_nxt;
            r_bi      <= w_bi_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_d_bit   <= w_d_bit_nxt;
            r_d_valid <= w_d_valid_nxt;
            r_done    <= w_done_nxt;
            r_diff    <= w_diff_nxt;
            r_borrow  <= w_borrow_nxt;
        end
    end

    assign busy    = r_busy;
    assign d_bit   = r_d_bit;
    assign d_valid = r_d_valid;
    assign diff    = r_diff;
    assign borrow  = r_borrow;
    assign done    = r_done;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled on the rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-008 The block SHALL have port d_bit, output, 1 bit: serial difference bit, LSB first.
REQ-009 The block SHALL have port d_valid, output, 1 bit: d_bit is meaningful this cycle.
REQ-010 The block SHALL have port diff, output, WIDTH bits: parallel difference (a - b) mod 2^WIDTH.
REQ-011 The block SHALL have port borrow, output, 1 bit: final borrow-out; 1 when a < b unsigned.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, when start=1 at a rising edge, the block SHALL latch a and b into shift registers, clear the internal borrow, clear the bit counter, and enter RUN.
REQ-015 While the block is in RUN or DONE, start SHALL be ignored, and a and b SHALL NOT be re-sampled.
REQ-016 Each RUN cycle SHALL compute one half-subtractor-with-borrow step on the current LSBs x and y with borrow-in bi: d = x^y^bi and bo = (~x&y) | (~(x^y)&bi).
REQ-017 On each RUN step, bo SHALL become the next bi, both operand registers SHALL shift right by 1, d SHALL shift into the MSB of the diff register, and d SHALL be presented on d_bit.
REQ-018 d_valid SHALL be high for exactly WIDTH consecutive cycles, beginning the cycle after start is accepted, and low at all other times.
REQ-019 busy SHALL be high in exactly the same cycles as d_valid.
REQ-020 After the WIDTH-th step the block SHALL enter DONE: done=1 for exactly one cycle, the cycle immediately after the last d_valid, and then the block SHALL return to IDLE.
REQ-021 Total latency from the start-accept edge to done=1 SHALL be WIDTH+1 cycles.
REQ-022 diff and borrow SHALL be valid from the done cycle onward and SHALL hold until the next accepted start.
REQ-023 A new start may be accepted in the first IDLE cycle after DONE (back-to-back throughput of one operation per WIDTH+2 cycles).
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH: a=b SHALL give diff=0, borrow=0; any a<b SHALL give borrow=1.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.
REQ-026 d_bit SHALL be 0 whenever d_valid=0.

Reset
REQ-027 While rst=1 the block SHALL immediately force state=IDLE, busy=0, d_valid=0, d_bit=0, done=0, diff=0, borrow=0, and clear counter, internal borrow and operand registers, independent of clk.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; after rst deasserts, the first start SHALL begin a fresh operation.
REQ-029 start=1 coincident with rst=1 SHALL be ignored.

Verification
REQ-030 WIDTH=8, a=0x05, b=0x03, start pulse -> d_bit LSB-first 0,1,0,0,0,0,0,0 over 8 d_valid cycles; done on cycle 9; diff=0x02, borrow=0.
REQ-031 WIDTH=8, a=0x03, b=0x05 -> diff=0xFE, borrow=1; d_bit sequence 0,1,1,1,1,1,1,1.
REQ-032 WIDTH=8, a=0xFF, b=0x01, then back-to-back a=0x00, b=0x00 started in the first IDLE cycle -> diff=0xFE with borrow=0, then diff=0x00 with borrow=0; exactly two done pulses.
REQ-033 WIDTH=8, start asserted again during RUN with a=0x10, b=0x01 -> ignored; result equals the first operand pair only, with a single done pulse.
REQ-034 Assert rst in the 4th RUN cycle -> all outputs 0 immediately with no done; the next operation a=0x80, b=0x01 gives diff=0x7F, borrow=0.
REQ-035 Exhaustive WIDTH=4 sweep of all 256 a/b pairs -> diff and borrow match the reference model {borrow,diff} = {1'b0,a} - {1'b0,b}.
